gemm_requant_stage: RTL and testbench

GEMM_REQUANT_STAGE -- requirements
Module: gemm_requant_stage

---
 rtl/gemm_requant_stage.sv | 189 ++++++++++++++++++
 tb/tb_gemm_requant_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_requant_stage.sv
// rtl/gemm_requant_stage.sv - int32 GEMM accumulator requantizer to int8 with per-channel scale/bias
// Define QUANT_RELU_EN to clamp outputs to [0,127] instead of [-128,127].
module gemm_requant_stage #(
  parameter int LANES  = 8,
  parameter int CH_MAX = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [4:0]            cfg_shift,
  input  logic [6:0]            cfg_channels,
  input  logic [7:0]            cfg_col_beats,
  input  logic [15:0]           cfg_rows,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [63:0]           p_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [32*LANES-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [8*LANES-1:0]    m_data,
  output logic                  m_last
);

  localparam int CW = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;
  localparam logic signed [49:0] Y_MAX = 50'sd127;
`ifdef QUANT_RELU_EN
  localparam logic signed [49:0] Y_MIN = 50'sd0;
`else
  localparam logic signed [49:0] Y_MIN = -50'sd128;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [4:0]  shift_q;
  logic [6:0]  chans_q;
  logic [7:0]  cbeats_q;
  logic [15:0] rows_q;
  logic [6:0]  k_q;
  logic [7:0]  cb_q;
  logic [15:0] r_q;

  logic [15:0] scale_tab [CH_MAX];
  logic [31:0] bias_tab  [CH_MAX];

  logic en, p_fire, s_fire, beat_last, done_set;
  logic v1, v2, v3, last1, last2;
  logic [8*LANES-1:0] y_all;
  logic unused_ok;

  assign en        = !v3 || m_ready;
  assign p_ready   = (state == LOAD);
  assign s_ready   = (state == RUN) && en;
  assign p_fire    = p_valid && p_ready;
  assign s_fire    = s_valid && s_ready;
  assign beat_last = (cb_q == cbeats_q - 8'd1) && (r_q == rows_q - 16'd1);
  assign busy      = (state != IDLE);
  assign m_valid   = v3;
  assign unused_ok = ^p_data[31:16];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  if (p_fire && k_q == chans_q - 7'd1) state_nxt = RUN;
      RUN:   if (s_fire && beat_last) state_nxt = FLUSH;
      FLUSH: begin
        if (v3 && m_last && m_ready) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config is frozen for the whole job; start is only honoured from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      shift_q  <= '0;
      chans_q  <= '0;
      cbeats_q <= '0;
      rows_q   <= '0;
      k_q      <= '0;
      cb_q     <= '0;
      r_q      <= '0;
    end else begin
      done <= done_set;
      if (state == IDLE && start) begin
        shift_q  <= cfg_shift;
        chans_q  <= cfg_channels;
        cbeats_q <= cfg_col_beats;
        rows_q   <= cfg_rows;
        k_q      <= '0;
        cb_q     <= '0;
        r_q      <= '0;
      end
      if (p_fire) k_q <= k_q + 7'd1;
      if (s_fire) begin
        if (cb_q == cbeats_q - 8'd1) begin
          cb_q <= '0;
          r_q  <= r_q + 16'd1;
        end else begin
          cb_q <= cb_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (p_fire && 32'(k_q) < 32'(CH_MAX)) begin
      scale_tab[k_q[CW-1:0]] <= p_data[15:0];
      bias_tab[k_q[CW-1:0]]  <= p_data[63:32];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0]        ch;
    logic               hit;
    logic [CW-1:0]      idx;
    logic [15:0]        sc;
    logic [31:0]        bi;
    logic [31:0]        acc;
    logic signed [32:0] t1;
    logic [15:0]        sc1;
    logic signed [49:0] p2;
    logic signed [49:0] rnd;
    logic signed [49:0] sum;
    logic signed [49:0] y;
    logic [7:0]         y8;

    // Channels beyond the loaded table behave as identity scale with zero bias.
    assign ch  = 32'(cb_q) * 32'(LANES) + 32'(i);
    assign hit = (ch < 32'(chans_q)) && (ch < 32'(CH_MAX));
    assign idx = ch[CW-1:0];
    assign sc  = hit ? scale_tab[idx] : 16'd1;
    assign bi  = hit ? bias_tab[idx] : 32'd0;
    assign acc = s_data[32*i +: 32];

    always_ff @(posedge clk) begin
      if (en) begin
        if (s_fire) begin
          t1  <= $signed({acc[31], acc}) + $signed({bi[31], bi});
          sc1 <= sc;
        end
        if (v1) p2 <= $signed({{17{t1[32]}}, t1}) * $signed({34'd0, sc1});
      end
    end

    assign rnd = (shift_q == 5'd0) ? 50'sd0 : (50'sd1 <<< (shift_q - 5'd1));
    assign sum = p2 + rnd;
    assign y   = sum >>> shift_q;
    assign y8  = (y > Y_MAX) ? Y_MAX[7:0] : (y < Y_MIN) ? Y_MIN[7:0] : y[7:0];
    assign y_all[8*i +: 8] = y8;
  end

  // Single enable stalls all three stages together so output data holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      last1  <= 1'b0;
      last2  <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
    end else if (en) begin
      v1     <= s_fire;
      last1  <= s_fire && beat_last;
      v2     <= v1;
      last2  <= v1 && last1;
      v3     <= v2;
      m_last <= v2 && last2;
      if (v2) m_data <= y_all;
    end
  end

endmodule

// File: tb/tb_gemm_requant_stage.sv
// tb/tb_gemm_requant_stage.sv - scoreboard bench for gemm_requant_stage
module tb_gemm_requant_stage;
  localparam int LANES  = 8;
  localparam int CH_MAX = 64;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [4:0] cfg_shift;
  logic [6:0] cfg_channels;
  logic [7:0] cfg_col_beats;
  logic [15:0] cfg_rows;
  logic p_valid, p_ready;
  logic [63:0] p_data;
  logic s_valid, s_ready;
  logic [32*LANES-1:0] s_data;
  logic m_valid, m_ready, m_last;
  logic [8*LANES-1:0] m_data;

  gemm_requant_stage #(.LANES(LANES), .CH_MAX(CH_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_shift(cfg_shift), .cfg_channels(cfg_channels),
    .cfg_col_beats(cfg_col_beats), .cfg_rows(cfg_rows),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*LANES-1:0] data;
    logic               last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int vectors = 0;
  int miscompares = 0;
  int tb_scale[CH_MAX];
  int tb_bias[CH_MAX];
  int acc_mode, acc_const, ready_mode, start_poke_cycle;
  int timeout_flag, unstable, done_after, done_early, busy_after;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] model_lane(input int acc, input int ch, input int chans, input int shift);
    longint sc, bi, t, p, y;
    if (ch < chans) begin
      sc = longint'(tb_scale[ch]);
      bi = longint'(tb_bias[ch]);
    end else begin
      sc = 1;
      bi = 0;
    end
    t = longint'(acc) + bi;
    p = t * sc;
    if (shift > 0) y = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    else y = p;
    if (y > 127) y = 127;
`ifdef QUANT_RELU_EN
    if (y < 0) y = 0;
`else
    if (y < -128) y = -128;
`endif
    return y[7:0];
  endfunction

  function automatic int gen_acc(input int lane);
    case (acc_mode)
      0: return lane;
      1: return acc_const;
      2: return (lane % 2 == 0) ? acc_const : -acc_const;
      default: return int'($urandom_range(0, 60000)) - 30000;
    endcase
  endfunction

  task automatic load_params(input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      p_data  = {tb_bias[k], 16'd0, tb_scale[k][15:0]};
      p_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!p_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) timeout_flag = 1;
      @(posedge clk); #1;
    end
    p_valid = 1'b0;
  endtask

  task automatic start_job(input int shift, input int chans, input int cbeats, input int rows);
    cfg_shift     = 5'(shift);
    cfg_channels  = 7'(chans);
    cfg_col_beats = 8'(cbeats);
    cfg_rows      = 16'(rows);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_params(chans);
  endtask

  task automatic drive_beats(input int shift, input int chans, input int cbeats, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cbeats; c++) begin
        logic [32*LANES-1:0] v;
        beat_t e;
        int w;
        for (int l = 0; l < LANES; l++) begin
          int a;
          a = gen_acc(l);
          v[32*l +: 32] = a;
          e.data[8*l +: 8] = model_lane(a, c * LANES + l, chans, shift);
        end
        e.last  = (r == rows - 1) && (c == cbeats - 1);
        s_data  = v;
        s_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin
          timeout_flag = 1;
          s_valid = 1'b0;
          return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    int cyc, got;
    logic prev_stall;
    logic [8*LANES-1:0] prev_d;
    logic prev_l;
    cyc = 0; got = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (got < n && cyc < 4000) begin
      @(posedge clk); #1;
      m_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clk);
      if (prev_stall && (m_data !== prev_d || m_last !== prev_l)) unstable++;
      if (done) done_early = 1;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (m_valid && m_ready) begin
        beat_t b;
        b.data = m_data;
        b.last = m_last;
        obs_q.push_back(b);
        got++;
      end
      cyc++;
    end
    if (got < n) timeout_flag = 1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic poke_start();
    if (start_poke_cycle >= 0) begin
      repeat (start_poke_cycle) @(posedge clk);
      #1;
      start = 1'b1;
      cfg_rows = 16'd1;
      cfg_channels = 7'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic run_job(input int shift, input int chans, input int cbeats, input int rows);
    timeout_flag = 0; unstable = 0; done_after = 0; done_early = 0; busy_after = 1;
    start_job(shift, chans, cbeats, rows);
    fork
      drive_beats(shift, chans, cbeats, rows);
      capture(cbeats * rows);
      poke_start();
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (p_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p_ready: got %b expected 0", p_ready); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < CH_MAX; k++) begin tb_scale[k] = 1; tb_bias[k] = 0; end
    acc_mode = 0; ready_mode = 0; start_poke_cycle = -1;
    run_job(0, 16, 2, 23);
    vectors++; if (timeout_flag !== 0) begin miscompares++; $display("FAIL pass_timeout: got %0d expected 0", timeout_flag); end
    vectors++; if (obs_q.size() !== 46) begin miscompares++; $display("FAIL pass_count: got %0d expected 46", obs_q.size()); end
    if (obs_q.size() > 0) begin
      vectors++;
      if (obs_q[0].data !== 64'h0706050403020100) begin miscompares++; $display("FAIL pass_lane_index: got %h expected 0706050403020100", obs_q[0].data); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.data !== e.data || o.last !== e.last) begin
        miscompares++; $display("FAIL pass_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    vectors++; if (done_early !== 0) begin miscompares++; $display("FAIL pass_done_early: got %0d expected 0", done_early); end
    vectors++; if (done_after !== 1) begin miscompares++; $display("FAIL pass_done: got %0d expected 1", done_after); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_latency();
    logic [8*LANES-1:0] e;
    int lat, w;
    for (int k = 0; k < 8; k++) begin tb_scale[k] = 1; tb_bias[k] = 5; end
    timeout_flag = 0;
    start_job(0, 8, 1, 1);
    m_ready = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      s_data[32*l +: 32] = l * 10;
      e[8*l +: 8] = 8'(l * 10 + 5);
    end
    s_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_valid && lat < 10);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL latency: got %0d expected 3", lat); end
    vectors++; if (m_data !== e) begin miscompares++; $display("FAIL latency_data: got %h expected %h", m_data, e); end
    vectors++; if (m_last !== 1'b1) begin miscompares++; $display("FAIL latency_last: got %b expected 1", m_last); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL latency_done: got %b expected 1", done); end
  endtask

  task automatic test_round_bias();
    for (int k = 0; k < 8; k++) begin tb_scale[k] = 3; tb_bias[k] = 28; end
    acc_mode = 1; acc_const = 100; ready_mode = 0; start_poke_cycle = -1;
    run_job(2, 8, 2, 2);
    vectors++; if (obs_q.size() !== 4) begin miscompares++; $display("FAIL round_count: got %0d expected 4", obs_q.size()); end
    if (obs_q.size() >= 2) begin
      vectors++;
      if (obs_q[0].data !== 64'h6060606060606060) begin miscompares++; $display("FAIL round_96: got %h expected 6060606060606060", obs_q[0].data); end
      vectors++;
      if (obs_q[1].data !== 64'h1919191919191919) begin miscompares++; $display("FAIL round_default_ch: got %h expected 1919191919191919", obs_q[1].data); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.data !== e.data || o.last !== e.last) begin
        miscompares++; $display("FAIL round_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturate();
    logic [63:0] sat_exp;
`ifdef QUANT_RELU_EN
    sat_exp = 64'h007f007f007f007f;
`else
    sat_exp = 64'h807f807f807f807f;
`endif
    for (int k = 0; k < 8; k++) begin tb_scale[k] = 1; tb_bias[k] = 0; end
    acc_mode = 2; acc_const = 1000; ready_mode = 0; start_poke_cycle = -1;
    run_job(0, 8, 1, 2);
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL sat_count: got %0d expected 2", obs_q.size()); end
    while (obs_q.size() > 0) begin
      beat_t o;
      o = obs_q.pop_front();
      vectors++;
      if (o.data !== sat_exp) begin miscompares++; $display("FAIL sat_clamp: got %h expected %h", o.data, sat_exp); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    for (int k = 0; k < CH_MAX; k++) begin
      tb_scale[k] = int'($urandom_range(0, 400));
      tb_bias[k]  = int'($urandom_range(0, 10000)) - 5000;
    end
    acc_mode = 3; ready_mode = 1; start_poke_cycle = -1;
    run_job(6, 20, 4, 5);
    vectors++; if (timeout_flag !== 0) begin miscompares++; $display("FAIL stall_timeout: got %0d expected 0", timeout_flag); end
    vectors++; if (obs_q.size() !== 20) begin miscompares++; $display("FAIL stall_count: got %0d expected 20", obs_q.size()); end
    vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL stall_hold: got %0d changes expected 0", unstable); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.data !== e.data || o.last !== e.last) begin
        miscompares++; $display("FAIL stall_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    vectors++; if (done_after !== 1) begin miscompares++; $display("FAIL stall_done: got %0d expected 1", done_after); end
    ready_mode = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < CH_MAX; k++) begin tb_scale[k] = 1; tb_bias[k] = 0; end
    timeout_flag = 0;
    start_job(0, 16, 2, 23);
    m_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      int w;
      for (int l = 0; l < LANES; l++) s_data[32*l +: 32] = b + l;
      s_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, p_ready, s_ready, m_valid, m_last} !== 6'b0) begin
      miscompares++; $display("FAIL midrst_ctrl: got %b expected 000000", {busy, done, p_ready, s_ready, m_valid, m_last});
    end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL midrst_data: got %h expected 0", m_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < CH_MAX; k++) begin tb_scale[k] = 2; tb_bias[k] = -3 - k; end
    acc_mode = 3; ready_mode = 0; start_poke_cycle = -1;
    run_job(1, 24, 3, 4);
    vectors++; if (obs_q.size() !== 12) begin miscompares++; $display("FAIL midrst_rerun_count: got %0d expected 12", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.data !== e.data || o.last !== e.last) begin
        miscompares++; $display("FAIL midrst_rerun_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    vectors++; if (done_after !== 1) begin miscompares++; $display("FAIL midrst_rerun_done: got %0d expected 1", done_after); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 8; k++) begin tb_scale[k] = 5; tb_bias[k] = k * 7; end
    acc_mode = 3; ready_mode = 0; start_poke_cycle = 4;
    run_job(3, 8, 2, 6);
    start_poke_cycle = -1;
    vectors++; if (obs_q.size() !== 12) begin miscompares++; $display("FAIL start_ign_count: got %0d expected 12", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.data !== e.data || o.last !== e.last) begin
        miscompares++; $display("FAIL start_ign_beat: got %h/%b expected %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    vectors++; if (done_after !== 1) begin miscompares++; $display("FAIL start_ign_done: got %0d expected 1", done_after); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_ign_idle: got %b expected 0", busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_shift = '0; cfg_channels = '0; cfg_col_beats = '0; cfg_rows = '0;
    p_valid = 1'b0; p_data = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    acc_mode = 0; acc_const = 0; ready_mode = 0; start_poke_cycle = -1;
    timeout_flag = 0; unstable = 0; done_after = 0; done_early = 0; busy_after = 0;
    test_reset();
    test_passthrough();
    test_latency();
    test_round_bias();
    test_saturate();
    test_stall();
    test_reset_mid_run();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
